// File: rtl/video_vga_dblsync.sv
// VGA scandoubler timing scheduler: locks onto the TV line strobe, emits double-rate
// hsync and line-buffer sequencing strobes, and flywheels over up to two missing strobes.
module video_vga_dblsync #(
   parameter int LINE_LEN    = 1792,
   parameter int HSYNC_LEN   = 96,
   parameter int SCANIN_DLY  = 40,
   parameter int SCANOUT_DLY = 24
) (
   input  logic clk,
   input  logic rst,
   input  logic line_start,
   output logic hsync_start,
   output logic scanin_start,
   output logic scanout_start,
   output logic vga_hsync,
   output logic locked
);

   typedef enum logic [1:0] {
      SEARCH  = 2'd0,
      MEASURE = 2'd1,
      LOCKED  = 2'd2
   } state_t;

   localparam logic [10:0] LAST      = 11'(LINE_LEN - 1);
   localparam logic [10:0] HALF      = 11'(LINE_LEN / 2);
   localparam logic [10:0] HS_END0   = 11'(HSYNC_LEN);
   localparam logic [10:0] HS_END1   = 11'(LINE_LEN / 2 + HSYNC_LEN);
   localparam logic [10:0] SCANIN    = 11'(SCANIN_DLY);
   localparam logic [10:0] SCANOUT0  = 11'(SCANOUT_DLY);
   localparam logic [10:0] SCANOUT1  = 11'(SCANOUT_DLY + LINE_LEN / 2);

   state_t      state, state_nxt;
   logic [10:0] lcnt, lcnt_nxt;
   logic [1:0]  miss, miss_nxt;
   logic        at_last;

   assign at_last = (lcnt == LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= SEARCH;
         lcnt  <= '0;
         miss  <= '0;
      end else begin
         state <= state_nxt;
         lcnt  <= lcnt_nxt;
         miss  <= miss_nxt;
      end
   end

   // A strobe off the expected period drops back to MEASURE; a missing strobe is
   // bridged by wrapping lcnt locally until the third consecutive miss.
   always_comb begin
      state_nxt = state;
      lcnt_nxt  = lcnt;
      miss_nxt  = miss;
      case (state)
         SEARCH: begin
            lcnt_nxt = '0;
            if (line_start) state_nxt = MEASURE;
         end
         MEASURE: begin
            lcnt_nxt = lcnt + 11'd1;
            if (line_start) begin
               lcnt_nxt = '0;
               if (at_last) begin
                  state_nxt = LOCKED;
                  miss_nxt  = '0;
               end
            end else if (at_last) begin
               state_nxt = SEARCH;
               lcnt_nxt  = '0;
            end
         end
         LOCKED: begin
            lcnt_nxt = lcnt + 11'd1;
            if (line_start) begin
               lcnt_nxt = '0;
               miss_nxt = '0;
               if (!at_last) state_nxt = MEASURE;
            end else if (at_last) begin
               lcnt_nxt = '0;
               if (miss == 2'd2) begin
                  state_nxt = SEARCH;
                  miss_nxt  = '0;
               end else begin
                  miss_nxt = miss + 2'd1;
               end
            end
         end
         default: begin
            state_nxt = SEARCH;
            lcnt_nxt  = '0;
            miss_nxt  = '0;
         end
      endcase
   end

   // Outputs are registered decodes of the current lcnt, gated by the LOCKED state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hsync_start   <= 1'b0;
         scanin_start  <= 1'b0;
         scanout_start <= 1'b0;
         vga_hsync     <= 1'b0;
         locked        <= 1'b0;
      end else begin
         hsync_start   <= (state == LOCKED) && ((lcnt == '0) || (lcnt == HALF));
         scanin_start  <= (state == LOCKED) && (lcnt == SCANIN);
         scanout_start <= (state == LOCKED) && ((lcnt == SCANOUT0) || (lcnt == SCANOUT1));
         vga_hsync     <= (state == LOCKED) &&
                          ((lcnt < HS_END0) || ((lcnt >= HALF) && (lcnt < HS_END1)));
         locked        <= (state == LOCKED);
      end
   end

endmodule

// File: tb/tb_video_vga_dblsync.sv
// Directed self-checking bench for video_vga_dblsync: lock, flywheel, phase jump,
// mid-line reset and bad strobe period, with hand-computed pulse positions.
module tb_video_vga_dblsync;

   logic clk = 1'b0;
   logic rst;
   logic line_start;
   logic hsync_start;
   logic scanin_start;
   logic scanout_start;
   logic vga_hsync;
   logic locked;

   int numCompared = 0;
   int numMismatched = 0;

   // Per-window observations; index i is sampled 1 time unit after the i-th edge,
   // where edge 0 is the one that samples the strobe (or would have).
   int hsCnt, hsPos0, hsPos1;
   int siCnt, siPos0;
   int soCnt, soPos0, soPos1;
   int vhCnt, vhFirst, vhLast;
   int lockAt1, lockEnd;

   video_vga_dblsync dut (
      .clk          (clk),
      .rst          (rst),
      .line_start   (line_start),
      .hsync_start  (hsync_start),
      .scanin_start (scanin_start),
      .scanout_start(scanout_start),
      .vga_hsync    (vga_hsync),
      .locked       (locked)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input int observed, input int expected);
      numCompared++;
      if (observed !== expected) begin
         numMismatched++;
         $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
      end
   endtask

   // Drives an optional strobe on the first edge, then records outputs for len edges.
   task automatic applyStimulus(input bit strobe, input int len);
      hsCnt = 0; hsPos0 = -1; hsPos1 = -1;
      siCnt = 0; siPos0 = -1;
      soCnt = 0; soPos0 = -1; soPos1 = -1;
      vhCnt = 0; vhFirst = -1; vhLast = -1;
      lockAt1 = -1; lockEnd = -1;
      for (int i = 0; i < len; i++) begin
         line_start = strobe && (i == 0);
         @(posedge clk);
         #1;
         line_start = 1'b0;
         if (hsync_start) begin
            if (hsCnt == 0) hsPos0 = i;
            else if (hsCnt == 1) hsPos1 = i;
            hsCnt++;
         end
         if (scanin_start) begin
            if (siCnt == 0) siPos0 = i;
            siCnt++;
         end
         if (scanout_start) begin
            if (soCnt == 0) soPos0 = i;
            else if (soCnt == 1) soPos1 = i;
            soCnt++;
         end
         if (vga_hsync) begin
            if (vhFirst < 0) vhFirst = i;
            vhLast = i;
            vhCnt++;
         end
         if (i == 1) lockAt1 = int'(locked);
         lockEnd = int'(locked);
      end
   endtask

   task automatic expectFullLine(input string tag);
      checkOutput({tag, "_hs_cnt"}, hsCnt, 2);
      checkOutput({tag, "_hs_pos0"}, hsPos0, 1);
      checkOutput({tag, "_hs_pos1"}, hsPos1, 897);
      checkOutput({tag, "_si_cnt"}, siCnt, 1);
      checkOutput({tag, "_si_pos"}, siPos0, 41);
      checkOutput({tag, "_so_cnt"}, soCnt, 2);
      checkOutput({tag, "_so_pos0"}, soPos0, 25);
      checkOutput({tag, "_so_pos1"}, soPos1, 921);
      checkOutput({tag, "_vh_cnt"}, vhCnt, 192);
      checkOutput({tag, "_vh_first"}, vhFirst, 1);
      checkOutput({tag, "_vh_last"}, vhLast, 992);
      checkOutput({tag, "_lock_end"}, lockEnd, 1);
   endtask

   task automatic expectSilentLine(input string tag);
      checkOutput({tag, "_hs_cnt"}, hsCnt, 0);
      checkOutput({tag, "_si_cnt"}, siCnt, 0);
      checkOutput({tag, "_so_cnt"}, soCnt, 0);
      checkOutput({tag, "_vh_cnt"}, vhCnt, 0);
      checkOutput({tag, "_lock_end"}, lockEnd, 0);
   endtask

   initial begin
      // Reset held with a strobe present: it must be ignored.
      rst = 1'b1;
      line_start = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("rst_outputs",
                  int'({hsync_start, scanin_start, scanout_start, vga_hsync, locked}), 0);
      line_start = 1'b0;
      rst = 1'b0;

      // First strobe directly after release enters MEASURE; second one locks.
      applyStimulus(1'b1, 1792);
      expectSilentLine("measure");
      applyStimulus(1'b1, 1792);
      checkOutput("lock1_at1", lockAt1, 1);
      expectFullLine("lock1");
      applyStimulus(1'b1, 1792);
      expectFullLine("lock2");

      // Flywheel: two misses keep timing, the third drops to SEARCH.
      applyStimulus(1'b0, 1792);
      expectFullLine("miss1");
      applyStimulus(1'b0, 1792);
      expectFullLine("miss2");
      applyStimulus(1'b0, 1792);
      checkOutput("miss3_at1", lockAt1, 0);
      expectSilentLine("miss3");

      // Relock, then a strobe at lcnt=1000 is a phase jump.
      applyStimulus(1'b1, 1792);
      expectSilentLine("relock_meas");
      applyStimulus(1'b1, 1001);
      checkOutput("prejump_at1", lockAt1, 1);
      checkOutput("prejump_hs_cnt", hsCnt, 2);
      checkOutput("prejump_so_cnt", soCnt, 2);
      applyStimulus(1'b1, 1792);
      checkOutput("jump_at1", lockAt1, 0);
      expectSilentLine("jump");
      applyStimulus(1'b1, 1792);
      checkOutput("jump_relock_at1", lockAt1, 1);
      expectFullLine("jump_relock");

      // Reset while vga_hsync is high (lcnt=50) must drop it without a clock edge.
      applyStimulus(1'b1, 51);
      checkOutput("pre_rst_vh", int'(vga_hsync), 1);
      checkOutput("pre_rst_lock", int'(locked), 1);
      rst = 1'b1;
      #1;
      checkOutput("async_rst_vh", int'(vga_hsync), 0);
      checkOutput("async_rst_lock", int'(locked), 0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;

      // Strobes 1790 cycles apart never lock.
      for (int n = 0; n < 4; n++) begin
         applyStimulus(1'b1, 1790);
         expectSilentLine($sformatf("bad%0d", n));
      end

      // Two correctly spaced strobes are needed again after the bad period.
      applyStimulus(1'b1, 1792);
      expectSilentLine("post_bad_meas");
      applyStimulus(1'b1, 1792);
      checkOutput("post_bad_at1", lockAt1, 1);
      expectFullLine("post_bad_lock");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numMismatched);
      $finish;
   end

endmodule

// File: doc/video_vga_dblsync.md
VIDEO_VGA_DBLSYNC -- requirements
Module: video_vga_dblsync

Purpose: timing scheduler for the VGA scandoubler line buffer. Locks to the TV line strobe and generates the double-rate VGA hsync plus the buffer-sequencing strobes `hsync_start`, `scanin_start` and `scanout_start`. Flywheels across missing strobes.

Interface
REQ-001 SHALL have parameter `LINE_LEN`, default 1792: TV line period in clk cycles; even; at most 2047.
REQ-002 SHALL have parameter `HSYNC_LEN`, default 96: VGA hsync pulse width in cycles; less than `LINE_LEN/2`.
REQ-003 SHALL have parameter `SCANIN_DLY`, default 40: lcnt value at which the TV-line write start is issued; less than `LINE_LEN`.
REQ-004 SHALL have parameter `SCANOUT_DLY`, default 24: lcnt offset, within each half-line, at which the read start is issued; less than `LINE_LEN/2`.
REQ-005 SHALL have port `clk`, input, 1 bit: system clock; all logic sits on its rising edge.
REQ-006 SHALL have port `rst`, input, 1 bit: reset, asynchronous and active-high.
REQ-007 SHALL have port `line_start`, input, 1 bit: one-cycle TV line start strobe.
REQ-008 SHALL have port `hsync_start`, output, 1 bit: one-cycle pulse at each VGA (half-)line start; drives the page swap.
REQ-009 SHALL have port `scanin_start`, output, 1 bit: one-cycle pulse, once per TV line, restarting the buffer write pointer.
REQ-010 SHALL have port `scanout_start`, output, 1 bit: one-cycle pulse, twice per TV line, restarting the buffer read pointer.
REQ-011 SHALL have port `vga_hsync`, output, 1 bit: active-high VGA horizontal sync.
REQ-012 SHALL have port `locked`, output, 1 bit: high while the FSM is in LOCKED.

Function
REQ-013 SHALL keep an 11-bit line counter `lcnt` and a 2-bit miss counter `miss`.
REQ-014 SHALL implement FSM states SEARCH, MEASURE and LOCKED.
REQ-015 SEARCH: lcnt held at 0; on `line_start` go to MEASURE with lcnt=0.
REQ-016 MEASURE: lcnt increments each cycle.
- On `line_start` with lcnt==LINE_LEN-1: go to LOCKED, lcnt=0, miss=0.
- On `line_start` with any other lcnt: stay in MEASURE, lcnt=0.
- With lcnt==LINE_LEN-1 and no `line_start`: go to SEARCH.
REQ-017 LOCKED: lcnt increments each cycle.
- On `line_start` with lcnt==LINE_LEN-1: stay in LOCKED, lcnt=0, miss=0.
- On `line_start` with lcnt!=LINE_LEN-1: go to MEASURE, lcnt=0, miss=0.
REQ-018 LOCKED flywheel: with lcnt==LINE_LEN-1 and no `line_start`, set lcnt=0 and increment miss; if miss was already 2, go to SEARCH instead.
REQ-019 All outputs SHALL be registered decodes of the current state and lcnt, so they appear one cycle after the matching lcnt value. A `line_start` sampled at edge E gives `hsync_start` high in the cycle after edge E+1 (2-clock latency).
REQ-020 `hsync_start` SHALL pulse for lcnt==0 and for lcnt==LINE_LEN/2.
REQ-021 `scanin_start` SHALL pulse for lcnt==SCANIN_DLY only.
REQ-022 `scanout_start` SHALL pulse for lcnt==SCANOUT_DLY and for lcnt==SCANOUT_DLY+LINE_LEN/2.
REQ-023 `vga_hsync` SHALL be high for lcnt in [0, HSYNC_LEN-1] and in [LINE_LEN/2, LINE_LEN/2+HSYNC_LEN-1].
REQ-024 Every output except `locked` SHALL be forced to 0 whenever the state is not LOCKED.
REQ-025 `locked` SHALL be the registered version of (state==LOCKED).
REQ-026 A pulse already registered when LOCKED is left SHALL still complete its single cycle; no further pulses follow.
REQ-027 Flywheel half-lines SHALL produce exactly the same output pattern as strobed lines.

Reset
REQ-028 While `rst` is high:
- state=SEARCH, lcnt=0, miss=0;
- all outputs 0, asynchronously;
- `line_start` ignored.
REQ-029 On `rst` deassertion, the first `line_start` SHALL be honoured in the first cycle after release.
REQ-030 An `rst` pulse in mid-line SHALL abort any pulse in progress, including forcing `vga_hsync` low immediately.

Verification
REQ-031 Lock: `line_start` every 1792 cycles from reset →
- 2nd strobe sets `locked`=1, 2 clocks later;
- after that, `hsync_start` at +2 and +898, `scanin_start` at +42, `scanout_start` at +26 and +922 relative to each strobe;
- `vga_hsync` 96 cycles wide.
REQ-032 Flywheel: locked, then strobes withheld →
- 2 missed lines keep full output timing;
- 3rd miss → SEARCH, `locked`=0, no further pulses.
REQ-033 Phase jump: locked, then strobe at lcnt=1000 → MEASURE, `locked`=0 and outputs silent; relock after the next correctly spaced strobe.
REQ-034 Bad period: strobes every 1790 cycles → `locked` never asserts, all outputs stay 0.
REQ-035 Reset mid-`vga_hsync` (lcnt=50) → `vga_hsync` drops asynchronously; after release, `locked`=0 until two correctly spaced strobes are seen.
